// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM encoding and default parameters for the PC sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HOLD   = 2'b10,
    HALTED = 2'b11
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_RESET_VECTOR = 0;
endpackage

// File: rtl/pc_sequencer_incrementor.sv
// pc_incrementor: ripple chain of half adders adding a constant carry-in of 1
module pc_incrementor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]  = a[i] ^ c[i];
    assign c[i+1]  = a[i] & c[i];
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with fetch handshake, branch, stall, halt and sticky wrap flag
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_en,
  input  logic [WIDTH-1:0] br_addr,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             iack,
  output logic             ireq,
  output logic [WIDTH-1:0] iaddr,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] faddr,
  output logic             wrap
);
  state_t           state, nxt;
  logic             fire, cout;
  logic [WIDTH-1:0] sum;
  pc_incrementor #(.WIDTH(WIDTH)) u_inc (.a(pc), .sum(sum), .cout(cout));
  assign iaddr = pc;
  // a halt request swallows a simultaneous acknowledge; a branch does not
  assign fire = state == FETCH && iack && !halt_req;
  always_comb
    nxt = state == HALTED ? (resume && !halt_req ? FETCH : HALTED) :
          halt_req ? HALTED :
          br_en ? IDLE :
          (state == FETCH && !iack) ? FETCH :
          stall ? HOLD : FETCH;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      ireq     <= 1'b0;
      pc_valid <= 1'b0;
      faddr    <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= nxt;
      ireq     <= nxt == FETCH;
      pc_valid <= fire;
      if (fire) faddr <= pc;
      if (state != HALTED && !halt_req) begin
        if (br_en) pc <= br_addr;
        else if (fire) begin
          pc <= sum;
          if (cout) wrap <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic checked against a behavioural model
module tb_pc_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       br_en = 0, stall = 0, halt_req = 0, resume = 0, iack = 0;
  logic [7:0] br_addr = 0;
  logic       ireq, pc_valid, wrap;
  logic [7:0] iaddr, pc, faddr;
  int checks = 0, errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .br_en(br_en), .br_addr(br_addr), .stall(stall),
    .halt_req(halt_req), .resume(resume), .iack(iack), .ireq(ireq), .iaddr(iaddr),
    .pc(pc), .pc_valid(pc_valid), .faddr(faddr), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // model: whether a fetch is being requested, whether the core is halted; everything else is idle/hold
  logic       m_fetch, m_halted, m_pv, m_wrap;
  logic [7:0] m_pc, m_faddr;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_fetch = 0; m_halted = 0; m_pv = 0; m_wrap = 0; m_pc = 8'h00; m_faddr = 8'h00;
    end else begin
      m_pv = 0;
      if (m_halted) begin
        if (resume && !halt_req) begin m_halted = 0; m_fetch = 1; end
      end else if (halt_req) begin
        m_halted = 1; m_fetch = 0;
      end else if (br_en) begin
        if (m_fetch && iack) begin m_pv = 1; m_faddr = m_pc; end
        m_pc = br_addr; m_fetch = 0;
      end else if (m_fetch && iack) begin
        m_pv = 1; m_faddr = m_pc;
        if (m_pc == 8'hFF) m_wrap = 1;
        m_pc = m_pc + 8'd1;
        m_fetch = !stall;
      end else if (!m_fetch) m_fetch = !stall;
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ireq", ireq, m_fetch);
    chk("iaddr", iaddr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_valid", pc_valid, m_pv);
    chk("faddr", faddr, m_faddr);
    chk("wrap", wrap, m_wrap);
  end

  task automatic cyc(input logic b, input logic [7:0] ba, input logic s, input logic h,
                     input logic r, input logic a);
    br_en = b; br_addr = ba; stall = s; halt_req = h; resume = r; iack = a;
    @(negedge clk);
  endtask

  task automatic jump(input logic [7:0] t);
    cyc(1, t, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #3;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ireq", ireq, 0);
    chk("rst_pv", pc_valid, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 0, 0, 0, 1);
    chk("first_ireq", ireq, 1);
    chk("first_iaddr", iaddr, 8'h00);
    chk("first_pv", pc_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("seq_pv", pc_valid, 1);
      chk("seq_faddr", faddr, i);
    end
    chk("seq_pc", pc, 8'h04);
    jump(8'h10);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("wait_pc", pc, 8'h10);
    cyc(1, 8'h80, 0, 0, 0, 0);
    chk("br_pc", pc, 8'h80);
    chk("br_pv", pc_valid, 0);
    chk("br_ireq", ireq, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("br_fetch", iaddr, 8'h80);
    jump(8'h05);
    cyc(0, 0, 1, 0, 0, 1);
    chk("stall_pv", pc_valid, 1);
    chk("stall_faddr", faddr, 8'h05);
    chk("stall_pc", pc, 8'h06);
    chk("stall_ireq", ireq, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("stall_hold", ireq, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_rel", ireq, 1);
    chk("stall_rel_a", iaddr, 8'h06);
    jump(8'h20);
    cyc(0, 0, 0, 1, 0, 1);
    chk("halt_pc", pc, 8'h20);
    chk("halt_pv", pc_valid, 0);
    cyc(1, 8'h55, 1, 0, 0, 1);
    chk("halt_br", pc, 8'h20);
    cyc(0, 0, 0, 1, 1, 0);
    chk("halt_both", ireq, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("resume_ireq", ireq, 1);
    chk("resume_a", iaddr, 8'h20);
    jump(8'hFF);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_set", wrap, 1);
    cyc(1, 8'h40, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_sticky", wrap, 1);
    #2 rst = 1;
    #1;
    chk("arst_wrap", wrap, 0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_ireq", ireq, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
      br_en = $urandom_range(0, 9) == 0; br_addr = a;
      stall = $urandom_range(0, 3) == 0; halt_req = $urandom_range(0, 19) == 0;
      resume = $urandom_range(0, 2) == 0; iack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
